check_seq_i8: RTL and testbench

Synthesizable self-check sequencer for an 8-bit constant/register datapath output. After a start pulse it waits a programmable hold-off (matching the 16-cycle reset window used in CI benches), then samples the datapath output `y` on a fixed number of valid steps, compares each sample against an expected value, and reports pass/fail with the failing step and data. It sits beside the device under test in CI hardware harnesses and on-board smoke tests, replacing the behavioural `$display`/`$finish` checkers.

---
 rtl/check_seq_i8_if.sv | 14 +
 rtl/check_seq_i8.sv | 121 ++++++++++++
 tb/tb_check_seq_i8.sv | 124 ++++++++++++
 3 files changed

// File: rtl/check_seq_i8_if.sv
// check_seq_i8_if: start/sample/result bundle between a check sequencer and the harness driving it.
interface check_seq_i8_if #(parameter int WIDTH = 8);
  logic start, y_valid, busy, done, pass, fail, timeout;
  logic [WIDTH-1:0] y, err_data;
  logic [7:0] step, err_step;
  modport master (
    output start, y, y_valid,
    input busy, done, pass, fail, timeout, step, err_step, err_data
  );
  modport slave (
    input start, y, y_valid,
    output busy, done, pass, fail, timeout, step, err_step, err_data
  );
endinterface

// File: rtl/check_seq_i8.sv
// check_seq_i8: waits HOLDOFF cycles after start, then compares STEPS valid samples of y against EXPECT.
// CHECK_SEQ_TIMEOUT_EN adds a RUN watchdog that fails the run after TIMEOUT cycles without y_valid.
module check_seq_i8 #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] EXPECT = WIDTH'(3),
  parameter int STEPS = 2,
  parameter int HOLDOFF = 16,
  parameter int TIMEOUT = 1024
) (
  input logic clock,
  input logic reset,
  check_seq_i8_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;
  localparam logic [7:0] last_step = 8'(STEPS);
  localparam logic [15:0] hold_last = 16'(HOLDOFF - 1);
  state_t state, state_n;
  logic [15:0] hold_cnt, hold_cnt_n;
  logic [7:0] step_q, step_n, err_step_q, err_step_n;
  logic [WIDTH-1:0] err_data_q, err_data_n;
  logic pass_q, pass_n, fail_q, fail_n, busy_q, done_q;
`ifdef CHECK_SEQ_TIMEOUT_EN
  localparam logic [15:0] wd_last = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt, wd_cnt_n;
  logic timeout_q, timeout_n;
`endif
  always_comb begin
    state_n = state;
    hold_cnt_n = hold_cnt;
    step_n = step_q;
    err_step_n = err_step_q;
    err_data_n = err_data_q;
    pass_n = pass_q;
    fail_n = fail_q;
`ifdef CHECK_SEQ_TIMEOUT_EN
    wd_cnt_n = '0;
    timeout_n = timeout_q;
`endif
    case (state)
      IDLE, DONE: if (bus.start) begin
        state_n = HOLDOFF > 0 ? HOLD : RUN;
        hold_cnt_n = '0;
        step_n = '0;
        err_step_n = '0;
        err_data_n = '0;
        pass_n = 1'b0;
        fail_n = 1'b0;
`ifdef CHECK_SEQ_TIMEOUT_EN
        timeout_n = 1'b0;
`endif
      end
      HOLD: if (hold_cnt == hold_last) state_n = RUN;
            else hold_cnt_n = hold_cnt + 16'd1;
      RUN: begin
        if (bus.y_valid) begin
          if (bus.y != EXPECT) begin
            err_step_n = step_q;
            err_data_n = bus.y;
            fail_n = 1'b1;
            state_n = DONE;
          end else begin
            step_n = step_q + 8'd1;
            pass_n = step_n == last_step;
            state_n = step_n == last_step ? DONE : RUN;
          end
        end
`ifdef CHECK_SEQ_TIMEOUT_EN
        else if (wd_cnt == wd_last) begin
          err_step_n = step_q;
          fail_n = 1'b1;
          timeout_n = 1'b1;
          state_n = DONE;
        end else wd_cnt_n = wd_cnt + 16'd1;
`endif
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      step_q <= '0;
      err_step_q <= '0;
      err_data_q <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef CHECK_SEQ_TIMEOUT_EN
      wd_cnt <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      hold_cnt <= hold_cnt_n;
      step_q <= step_n;
      err_step_q <= err_step_n;
      err_data_q <= err_data_n;
      pass_q <= pass_n;
      fail_q <= fail_n;
      busy_q <= state_n == HOLD || state_n == RUN;
      done_q <= state_n == DONE;
`ifdef CHECK_SEQ_TIMEOUT_EN
      wd_cnt <= wd_cnt_n;
      timeout_q <= timeout_n;
`endif
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.fail = fail_q;
  assign bus.step = step_q;
  assign bus.err_step = err_step_q;
  assign bus.err_data = err_data_q;
`ifdef CHECK_SEQ_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0 & (TIMEOUT == 0);
`endif
endmodule

// File: tb/tb_check_seq_i8.sv
// tb_check_seq_i8: randomized runs of check_seq_i8 against a per-run outcome model.
module tb_check_seq_i8;
  localparam int H = 16, S = 2, TO = 8, N = 64;
  localparam logic [7:0] EXP = 8'd3;
  logic clock = 1'b0, reset = 1'b0;
  int checks = 0, errors = 0;
  logic yv [N];
  logic [7:0] yd [N];
  check_seq_i8_if #(.WIDTH(8)) bus ();
  check_seq_i8 #(.WIDTH(8), .EXPECT(EXP), .STEPS(S), .HOLDOFF(H), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_pass"}, bus.pass, 0);
    chk({tag, "_fail"}, bus.fail, 0);
    chk({tag, "_timeout"}, bus.timeout, 0);
    chk({tag, "_step"}, bus.step, 0);
    chk({tag, "_err_step"}, bus.err_step, 0);
    chk({tag, "_err_data"}, bus.err_data, 0);
  endtask
  // mode 0 random, 1 all good, 2 mismatch on step 1, 3 gapped valids
  task automatic gen(input int mode);
    for (int i = 0; i < N; i++) begin
      yv[i] = mode == 0 ? ($urandom_range(9) < 6) : mode != 3;
      yd[i] = (mode == 0 && $urandom_range(7) == 0) ? 8'($urandom) : EXP;
    end
    if (mode == 0) for (int k = 1; k <= S; k++) yv[N-k] = 1'b1;
    if (mode == 2) yd[H+2] = 8'd5;
    if (mode == 3) begin
      yv[H+1] = 1'b1;
      yv[H+4] = 1'b1;
    end
  endtask
  // sample i is taken at the i-th edge after (and including) the start edge
  task automatic run_seq(input bit inj);
    int fin = -1, st = 0, gap = 0, es = 0;
    bit ps = 0, fl = 0, to = 0;
    logic [7:0] ed = 0;
    int steps_at [N];
    for (int i = 0; i < N; i++) begin
      if (fin < 0 && i > H) begin
        if (yv[i]) begin
          gap = 0;
          if (yd[i] != EXP) begin fl = 1; es = st; ed = yd[i]; fin = i; end
          else if (++st == S) begin ps = 1; fin = i; end
        end
`ifdef CHECK_SEQ_TIMEOUT_EN
        else if (++gap == TO) begin fl = 1; to = 1; es = st; fin = i; end
`endif
      end
      steps_at[i] = st;
    end
    for (int i = 0; i <= fin + 2; i++) begin
      @(negedge clock);
      bus.start = i == 0 || (inj && i <= fin && $urandom_range(3) == 0);
      bus.y_valid = i < N ? yv[i] : 1'b0;
      bus.y = i < N ? yd[i] : 8'h00;
      @(posedge clock);
      #1;
      chk("busy", bus.busy, i < fin);
      chk("done", bus.done, i >= fin);
      chk("step", bus.step, steps_at[i < N ? i : N-1]);
      chk("pass", bus.pass, i >= fin && ps);
      chk("fail", bus.fail, i >= fin && fl);
    end
    bus.start = 1'b0;
    chk("timeout", bus.timeout, to);
    chk("err_step", bus.err_step, fl ? es : 0);
    chk("err_data", bus.err_data, ed);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.y_valid = 1'b0;
    bus.y = 8'h00;
    repeat (2) @(posedge clock);
    #1 chk_idle("rst");
    @(negedge clock) reset = 1'b1;
    gen(1); run_seq(0);
    gen(2); run_seq(1);
    gen(1); run_seq(0);
    gen(3); run_seq(0);
    repeat (20) begin gen(0); run_seq(1); end
    @(negedge clock) begin bus.start = 1'b1; bus.y_valid = 1'b0; end
    @(negedge clock) bus.start = 1'b0;
    repeat (H + TO + 4) @(negedge clock);
`ifdef CHECK_SEQ_TIMEOUT_EN
    chk("to_done", bus.done, 1);
    chk("to_fail", bus.fail, 1);
    chk("to_flag", bus.timeout, 1);
    chk("to_err_step", bus.err_step, 0);
`else
    chk("to_busy", bus.busy, 1);
    chk("to_done", bus.done, 0);
`endif
    reset = 1'b0;
    @(negedge clock) reset = 1'b1;
    @(negedge clock) begin bus.start = 1'b1; bus.y_valid = 1'b0; end
    @(negedge clock) bus.start = 1'b0;
    repeat (H) @(negedge clock);
    bus.y_valid = 1'b1;
    bus.y = EXP;
    @(negedge clock) bus.y_valid = 1'b0;
    chk("mid_step", bus.step, 1);
    chk("mid_busy", bus.busy, 1);
    #2 reset = 1'b0;
    #1 chk_idle("mid_rst");
    @(negedge clock) reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("post_done", bus.done, 0);
    chk("post_busy", bus.busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
